seq_scan_ctrl: RTL

Run controller for serial pattern detection. It latches a programmable pattern and length, then accepts a qualified serial bit stream for a bounded scan window. It flags overlapping matches with a Moore-style registered output and counts matches. Software or a higher-level FSM uses it to arm, run and collect results from a bit-pattern detection pass, replacing hard-coded single-pattern detectors.

---
 rtl/seq_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Programmable serial pattern scanner: arm with a pattern/length/limit, then
// detect overlapping matches on a qualified bit stream and count them.
module seq_scan_ctrl #(
    parameter int W  = 8,
    parameter int LW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [15:0]   bit_limit,
    input  logic          x,
    input  logic          x_valid,
    output logic          z,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_count,
    output logic          overflow,
    output logic [1:0]    state_dbg
);

    // Handshake: a bit is consumed on every rising edge where the block is in
    // SCAN, x_valid is high and abort is low; there is no back-pressure.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, hist_q, hist_d, mask;
    logic [LW-1:0] len_q, len_eff, seen_q, seen_d;
    logic [15:0]   lim_q, cnt_q, cnt_d;
    logic          accept, hit, last_bit;

    assign len_eff = ((len == '0) || (len > LW'(W))) ? LW'(W) : len;

    // Only the low len_q bits of history and pattern take part in a compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign accept   = (state_q == SCAN) && x_valid && !abort;
    assign hist_d   = {hist_q[W-2:0], x};
    assign seen_d   = (seen_q == LW'(W)) ? seen_q : seen_q + 1'b1;
    assign cnt_d    = cnt_q + 16'd1;
    assign hit      = (seen_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);
    assign last_bit = accept && (lim_q != 16'd0) && (cnt_d == lim_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        state_dbg = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (abort)         state_d = IDLE;
                else if (last_bit) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q       <= '0;
            len_q       <= '0;
            lim_q       <= '0;
            hist_q      <= '0;
            seen_q      <= '0;
            cnt_q       <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
            z           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        len_q       <= len_eff;
                        lim_q       <= bit_limit;
                        hist_q      <= '0;
                        seen_q      <= '0;
                        cnt_q       <= '0;
                        match_count <= '0;
                        overflow    <= 1'b0;
                        z           <= 1'b0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        z <= 1'b0;
                    end else if (accept) begin
                        hist_q <= hist_d;
                        seen_q <= seen_d;
                        cnt_q  <= cnt_d;
                        z      <= hit;
                        // The counter pins at all-ones; the sticky flag records lost matches.
                        if (hit) begin
                            if (&match_count) overflow    <= 1'b1;
                            else              match_count <= match_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    z <= 1'b0;
                end
                default: begin
                    z <= 1'b0;
                end
            endcase
        end
    end

endmodule
